piece_ctrl: RTL and testbench
=============================

Name: piece_ctrl

Overview:
Sequences the active falling brick: spawn, gravity, player moves and rotation, hard drop, and handoff of the landed brick to the board writer.
Drives the active position, direction and type into the shared collision-check and drop-distance datapath.
Consumes the single-cycle combinational results from that datapath (candidate fits, drop shift).
Sits between the input/command decoder, the brick RNG and the board-update logic.

Parameters:
POS_W, 10, position width; row = pos[POS_W-1:5], column = pos[4:0]; one row down = pos - 32
BRICK_W, 3, brick type width
DIR_W, 2, direction width; rotation wraps modulo 4
SHIFT_W, 20, width of drop_shift input (BOARD_H)
GRAVITY_TICKS, 50, cycles between gravity steps (>=2)
SPAWN_POS, 10'd620, spawn position (row 19, column 12)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin game from IDLE or OVER
cmd_valid  in  1  player command valid
cmd  in  3  0=left 1=right 2=rotate 3=soft down 4=hard drop; 5-7 reserved
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
next_brick  in  BRICK_W  type offered by RNG
next_req  out  1  one-cycle pulse; RNG advances
pos  out  POS_W  active brick position
dir  out  DIR_W  active brick direction
brick_type  out  BRICK_W  active brick type
cand_pos  out  POS_W  candidate position to collision checker
cand_dir  out  DIR_W  candidate direction to collision checker
cand_fits  in  1  combinational: candidate is legal and unoccupied
drop_shift  in  SHIFT_W  combinational: rows the active brick can fall (0..19)
lock_valid  out  1  landed brick presented to board writer
lock_ready  in  1  board writer accepts
game_over  out  1  high in OVER

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pos=SPAWN_POS; dir=0; brick_type=0; gravity count=0.
  - cmd_ready, next_req, lock_valid, game_over all 0.
- States: IDLE, SPAWN, SPAWN_CHK, ACTIVE, LOCK, OVER.
- IDLE: start -> SPAWN. OVER: game_over=1; start -> SPAWN.
- SPAWN (1 cycle):
  - brick_type<=next_brick, pos<=SPAWN_POS, dir<=0, gravity count<=0.
  - next_req=1 this cycle.
  - -> SPAWN_CHK.
- SPAWN_CHK (1 cycle): cand=pos/dir. cand_fits=1 -> ACTIVE; otherwise -> OVER.
- ACTIVE:
  - Gravity count increments each cycle; grav_due = (count==GRAVITY_TICKS-1).
  - cmd_ready = (state==ACTIVE) && !grav_due. Gravity has priority; at most one action per cycle.
  - Gravity or soft down: cand_pos=pos-32, cand_dir=dir.
    - Fits: pos<=cand_pos, count<=0.
    - Not fits: -> LOCK (pos unchanged).
    - Row 0 is never decremented; a row-0 brick goes to LOCK.
  - Left: cand_pos=pos-1. Right: cand_pos=pos+1. Rotate: cand_dir=dir+1 (3 wraps to 0).
    - Fits: update; otherwise ignore, command still consumed.
    - Count is not reset by these.
  - Hard drop: no cand check; pos<=pos-(min(drop_shift,row)<<5), then -> LOCK.
  - Reserved cmd: consumed, no effect.
  - Idle cycles in ACTIVE: cand_pos=pos, cand_dir=dir.
- LOCK:
  - lock_valid=1; pos/dir/brick_type held stable.
  - On lock_valid&lock_ready -> SPAWN. A lock_ready already high on entry completes in that same cycle.
  - cmd_ready=0.
- Update timing: all registered updates take effect the cycle after the accepting edge. Outputs are registered except cmd_ready, lock_valid, game_over and cand_*, which are decoded from state and registers.
- start outside IDLE/OVER is ignored.
- Reset mid-operation returns everything to reset values immediately, including dropping a pending lock_valid.

Test Plan:
- Reset, start pulse with next_brick=3, cand_fits=1 -> next_req pulses once; brick_type=3, pos=620, dir=0; ACTIVE by cycle 3.
- ACTIVE, no cmds, cand_fits=1, GRAVITY_TICKS=4 -> pos becomes 588 after 4 cycles, 556 after 8; cmd_ready low exactly on each grav_due cycle.
- cmd=rotate x4, cand_fits=1 -> dir 1,2,3,0. cmd=left with cand_fits=0 -> pos unchanged, cmd consumed.
- Hard drop, drop_shift=7 at pos=620 -> pos=396; lock_valid=1 next cycle. With lock_ready low 3 cycles, outputs stay stable; lock_ready=1 -> SPAWN.
- Soft down at row 0, or with cand_fits=0 -> LOCK, pos unchanged.
- After a lock, next spawn with cand_fits=0 -> OVER, game_over=1, cmd_ready=0. A start pulse then re-spawns; asserting rst_n=0 in LOCK clears lock_valid asynchronously.

Source files
------------

// File: rtl/piece_ctrl.sv
// Active-brick sequencer: spawn, gravity, player moves/rotation, hard drop and lock handoff.
// Candidate moves go out combinationally to the shared collision checker and are judged in-cycle.
module piece_ctrl #(
  parameter int unsigned      POS_W         = 10,
  parameter int unsigned      BRICK_W       = 3,
  parameter int unsigned      DIR_W         = 2,
  parameter int unsigned      SHIFT_W       = 20,
  parameter int unsigned      GRAVITY_TICKS = 50,
  parameter logic [POS_W-1:0] SPAWN_POS     = 10'd620
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  output logic               cmd_ready,
  input  logic [BRICK_W-1:0] next_brick,
  output logic               next_req,
  output logic [POS_W-1:0]   pos,
  output logic [DIR_W-1:0]   dir,
  output logic [BRICK_W-1:0] brick_type,
  output logic [POS_W-1:0]   cand_pos,
  output logic [DIR_W-1:0]   cand_dir,
  input  logic               cand_fits,
  input  logic [SHIFT_W-1:0] drop_shift,
  output logic               lock_valid,
  input  logic               lock_ready,
  output logic               game_over
);

  localparam int unsigned ROW_W = POS_W - 5;
  localparam int unsigned CNT_W = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
  localparam logic [CNT_W-1:0] GravLast = CNT_W'(GRAVITY_TICKS - 1);
  localparam logic [POS_W-1:0] RowStep  = POS_W'(32);

  localparam logic [2:0] CmdLeft  = 3'd0;
  localparam logic [2:0] CmdRight = 3'd1;
  localparam logic [2:0] CmdRot   = 3'd2;
  localparam logic [2:0] CmdDown  = 3'd3;
  localparam logic [2:0] CmdDrop  = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StSpawnChk,
    StActive,
    StLock,
    StOver
  } state_e;

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [BRICK_W-1:0] type_q, type_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               next_req_q;

  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   drop_rows;
  logic [POS_W-1:0]   drop_amt;
  logic               grav_due;

  assign row      = pos_q[POS_W-1:5];
  assign grav_due = (cnt_q == GravLast);

  // Hard drop never takes the brick below row 0.
  always_comb begin
    drop_rows = row;
    if (drop_shift < SHIFT_W'(row)) begin
      drop_rows = drop_shift[ROW_W-1:0];
    end
  end

  assign drop_amt = {drop_rows, 5'b0};

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    type_d     = type_q;
    cnt_d      = cnt_q;
    cand_pos   = pos_q;
    cand_dir   = dir_q;
    cmd_ready  = 1'b0;
    lock_valid = 1'b0;
    game_over  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StSpawn;
      end
      StSpawn: begin
        type_d  = next_brick;
        pos_d   = SPAWN_POS;
        dir_d   = '0;
        cnt_d   = '0;
        state_d = StSpawnChk;
      end
      StSpawnChk: begin
        state_d = cand_fits ? StActive : StOver;
      end
      StActive: begin
        cmd_ready = !grav_due;
        cnt_d     = cnt_q + CNT_W'(1);
        // Gravity wins over any command; a soft down is just an early gravity step.
        if (grav_due || (cmd_valid && cmd == CmdDown)) begin
          cand_pos = pos_q - RowStep;
          if (row != '0 && cand_fits) begin
            pos_d = cand_pos;
            cnt_d = '0;
          end else begin
            state_d = StLock;
          end
        end else if (cmd_valid) begin
          case (cmd)
            CmdLeft: begin
              cand_pos = pos_q - POS_W'(1);
              if (cand_fits) pos_d = cand_pos;
            end
            CmdRight: begin
              cand_pos = pos_q + POS_W'(1);
              if (cand_fits) pos_d = cand_pos;
            end
            CmdRot: begin
              cand_dir = dir_q + DIR_W'(1);
              if (cand_fits) dir_d = cand_dir;
            end
            CmdDrop: begin
              pos_d   = pos_q - drop_amt;
              state_d = StLock;
            end
            default: ;
          endcase
        end
      end
      StLock: begin
        lock_valid = 1'b1;
        if (lock_ready) state_d = StSpawn;
      end
      StOver: begin
        game_over = 1'b1;
        if (start) state_d = StSpawn;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pos_q      <= SPAWN_POS;
      dir_q      <= '0;
      type_q     <= '0;
      cnt_q      <= '0;
      next_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      type_q     <= type_d;
      cnt_q      <= cnt_d;
      next_req_q <= (state_d == StSpawn);
    end
  end

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign brick_type = type_q;
  assign next_req   = next_req_q;

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed-vector bench for piece_ctrl: per-cycle expectations and lock handoffs are queued
// by the stimulus and checked by independent negedge monitors.
module tb_piece_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic [2:0] next_brick;
  logic       next_req;
  logic [9:0] pos;
  logic [1:0] dir;
  logic [2:0] brick_type;
  logic [9:0] cand_pos;
  logic [1:0] cand_dir;
  logic       cand_fits;
  logic [19:0] drop_shift;
  logic       lock_valid;
  logic       lock_ready;
  logic       game_over;

  piece_ctrl #(
    .GRAVITY_TICKS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .next_brick (next_brick),
    .next_req   (next_req),
    .pos        (pos),
    .dir        (dir),
    .brick_type (brick_type),
    .cand_pos   (cand_pos),
    .cand_dir   (cand_dir),
    .cand_fits  (cand_fits),
    .drop_shift (drop_shift),
    .lock_valid (lock_valid),
    .lock_ready (lock_ready),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] pos;
    logic [1:0] dir;
    logic [2:0] typ;
    logic [9:0] cpos;
    logic [1:0] cdir;
    logic       ready;
    logic       lv;
    logic       go;
    logic       nreq;
  } obs_t;

  typedef struct packed {
    logic [9:0] pos;
    logic [1:0] dir;
    logic [2:0] typ;
  } lk_t;

  obs_t  exp_q[$];
  string name_q[$];
  lk_t   lk_q[$];
  int    checks = 0;
  int    passed = 0;
  int    nreq_seen = 0;

  obs_t  mon_e, mon_a;
  string mon_n;
  lk_t   lk_e, lk_a;

  // Cycle monitor: compares every queued expectation against the outputs at mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = '{pos, dir, brick_type, cand_pos, cand_dir, cmd_ready, lock_valid, game_over,
                next_req};
      checks++;
      if (mon_a === mon_e) begin
        passed++;
      end else begin
        $display("FAIL %s: got pos=%0d dir=%0d type=%0d cand=%0d/%0d rdy=%b lv=%b go=%b nreq=%b; want pos=%0d dir=%0d type=%0d cand=%0d/%0d rdy=%b lv=%b go=%b nreq=%b",
                 mon_n, mon_a.pos, mon_a.dir, mon_a.typ, mon_a.cpos, mon_a.cdir, mon_a.ready,
                 mon_a.lv, mon_a.go, mon_a.nreq, mon_e.pos, mon_e.dir, mon_e.typ, mon_e.cpos,
                 mon_e.cdir, mon_e.ready, mon_e.lv, mon_e.go, mon_e.nreq);
      end
    end
  end

  // Lock monitor: every accepted handoff must match the next queued landed brick.
  always @(negedge clk) begin
    if (rst_n && lock_valid && lock_ready) begin
      lk_a = '{pos, dir, brick_type};
      checks++;
      if (lk_q.size() == 0) begin
        $display("FAIL lock_handoff: got unexpected lock pos=%0d dir=%0d type=%0d; want none",
                 lk_a.pos, lk_a.dir, lk_a.typ);
      end else begin
        lk_e = lk_q.pop_front();
        if (lk_a === lk_e) begin
          passed++;
        end else begin
          $display("FAIL lock_handoff: got pos=%0d dir=%0d type=%0d; want pos=%0d dir=%0d type=%0d",
                   lk_a.pos, lk_a.dir, lk_a.typ, lk_e.pos, lk_e.dir, lk_e.typ);
        end
      end
    end
    if (next_req === 1'b1) nreq_seen++;
  end

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic chk(input string name, input int p, input int d, input int t, input int cp,
                     input int cd, input bit r, input bit lv, input bit go, input bit nr);
    obs_t e;
    e = '{10'(p), 2'(d), 3'(t), 10'(cp), 2'(cd), r, lv, go, nr};
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic push_lock(input int p, input int d, input int t);
    lk_t e;
    e = '{10'(p), 2'(d), 3'(t)};
    lk_q.push_back(e);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 3'd0;
    next_brick = 3'd3;
    cand_fits  = 1'b1;
    drop_shift = 20'd0;
    lock_ready = 1'b0;
    @(posedge clk);
    #1;

    chk("reset",      620, 0, 0, 620, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("idle",       620, 0, 0, 620, 0, 0, 0, 0, 0);
    start = 1'b1;
    chk("idle_start", 620, 0, 0, 620, 0, 0, 0, 0, 0);
    start = 1'b0;
    chk("spawn",      620, 0, 0, 620, 0, 0, 0, 0, 1);
    chk("spawn_chk",  620, 0, 3, 620, 0, 0, 0, 0, 0);

    // Gravity every 4th ACTIVE cycle; cmd_ready drops only on the due cycle.
    for (int i = 0; i < 3; i++) chk("grav_wait1", 620, 0, 3, 620, 0, 1, 0, 0, 0);
    chk("grav_due1",  620, 0, 3, 588, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) chk("grav_wait2", 588, 0, 3, 588, 0, 1, 0, 0, 0);
    chk("grav_due2",  588, 0, 3, 556, 0, 0, 0, 0, 0);

    // Rotations do not reset the gravity count, so the 4th waits behind a gravity step.
    cmd_valid = 1'b1;
    cmd       = 3'd2;
    chk("rot1",       556, 0, 3, 556, 1, 1, 0, 0, 0);
    chk("rot2",       556, 1, 3, 556, 2, 1, 0, 0, 0);
    chk("rot3",       556, 2, 3, 556, 3, 1, 0, 0, 0);
    chk("rot_held",   556, 3, 3, 524, 3, 0, 0, 0, 0);
    chk("rot_wrap",   524, 3, 3, 524, 0, 1, 0, 0, 0);

    cmd       = 3'd0;
    cand_fits = 1'b0;
    chk("left_blocked", 524, 0, 3, 523, 0, 1, 0, 0, 0);
    cmd_valid = 1'b0;
    cand_fits = 1'b1;
    chk("left_kept",  524, 0, 3, 524, 0, 1, 0, 0, 0);
    chk("grav_due3",  524, 0, 3, 492, 0, 0, 0, 0, 0);

    cmd_valid = 1'b1;
    cmd       = 3'd1;
    chk("right",      492, 0, 3, 493, 0, 1, 0, 0, 0);
    cmd        = 3'd4;
    drop_shift = 20'd7;
    chk("hard_drop",  493, 0, 3, 493, 0, 1, 0, 0, 0);
    cmd_valid  = 1'b0;
    drop_shift = 20'd0;
    for (int i = 0; i < 3; i++) chk("lock_wait", 269, 0, 3, 269, 0, 0, 1, 0, 0);
    lock_ready = 1'b1;
    push_lock(269, 0, 3);
    chk("lock_go",    269, 0, 3, 269, 0, 0, 1, 0, 0);
    lock_ready = 1'b0;
    next_brick = 3'd5;
    chk("spawn2",     269, 0, 3, 269, 0, 0, 0, 0, 1);
    chk("spawn2_chk", 620, 0, 5, 620, 0, 0, 0, 0, 0);

    // Blocked soft down locks in place; lock_ready already high completes on entry.
    cmd_valid  = 1'b1;
    cmd        = 3'd3;
    cand_fits  = 1'b0;
    lock_ready = 1'b1;
    chk("soft_blocked", 620, 0, 5, 588, 0, 1, 0, 0, 0);
    cmd_valid = 1'b0;
    push_lock(620, 0, 5);
    chk("lock_instant", 620, 0, 5, 620, 0, 0, 1, 0, 0);
    lock_ready = 1'b0;
    next_brick = 3'd6;
    chk("spawn3",     620, 0, 5, 620, 0, 0, 0, 0, 1);
    chk("spawn3_chk", 620, 0, 6, 620, 0, 0, 0, 0, 0);
    cmd_valid = 1'b1;
    cmd       = 3'd3;
    chk("over",       620, 0, 6, 620, 0, 0, 0, 1, 0);
    cmd_valid = 1'b0;
    start     = 1'b1;
    chk("over_start", 620, 0, 6, 620, 0, 0, 0, 1, 0);
    start      = 1'b0;
    next_brick = 3'd2;
    cand_fits  = 1'b1;
    chk("spawn4",     620, 0, 6, 620, 0, 0, 0, 0, 1);
    chk("spawn4_chk", 620, 0, 2, 620, 0, 0, 0, 0, 0);

    // Soft down to the floor; each fitting step clears the gravity count.
    cmd_valid = 1'b1;
    cmd       = 3'd3;
    for (int k = 0; k < 19; k++) begin
      chk("soft_fall", 620 - 32 * k, 0, 2, 588 - 32 * k, 0, 1, 0, 0, 0);
    end
    chk("soft_row0",  12, 0, 2, 1004, 0, 1, 0, 0, 0);
    cmd_valid  = 1'b0;
    lock_ready = 1'b1;
    push_lock(12, 0, 2);
    chk("lock_row0",  12, 0, 2, 12, 0, 0, 1, 0, 0);
    lock_ready = 1'b0;
    next_brick = 3'd7;
    chk("spawn5",     12, 0, 2, 12, 0, 0, 0, 0, 1);
    chk("spawn5_chk", 620, 0, 7, 620, 0, 0, 0, 0, 0);

    // Drop distance beyond the current row is clamped to row 0.
    cmd_valid  = 1'b1;
    cmd        = 3'd4;
    drop_shift = 20'd33;
    chk("hard_drop_clamp", 620, 0, 7, 620, 0, 1, 0, 0, 0);
    cmd_valid  = 1'b0;
    drop_shift = 20'd0;
    chk("lock_hold",  12, 0, 7, 12, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    chk("reset_in_lock", 620, 0, 0, 620, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("idle_again", 620, 0, 0, 620, 0, 0, 0, 0, 0);

    checks++;
    if (nreq_seen == 5) begin
      passed++;
    end else begin
      $display("FAIL next_req_count: got %0d pulses; want 5", nreq_seen);
    end
    checks++;
    if (lk_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL lock_handoffs: got %0d handoffs missing; want 0", lk_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
